// File: rtl/dino_sprite_rom_if.sv
// Renderer-to-ROM pixel lookup bus: the sprite address goes out and the registered colour comes back.
interface dino_sprite_rom_if;
  logic [8:0] address;
  logic [2:0] q;

  modport master (output address, input q);
  modport slave  (input address, output q);
endinterface

// File: rtl/dino_sprite_rom.sv
// Fixed 3-frame 10x12 dinosaur sprite store with one cycle of read latency.
// A single output register holds the colour for the address sampled at the last rising edge.
module dino_sprite_rom #(
  parameter logic [2:0] INK   = 3'b000,
  parameter logic [2:0] PAPER = 3'b111
) (
  input  logic              clock,
  input  logic              resetn,
  dino_sprite_rom_if.slave  rom
);

  // Bit 9 is column 0 (leftmost), so each row reads the same way as the artwork.
  function automatic logic [9:0] body_row(input logic [3:0] row);
    logic [9:0] bits;
    case (row)
      4'd0:    bits = 10'b0000001111;
      4'd1:    bits = 10'b0000011011;
      4'd2:    bits = 10'b0000011111;
      4'd3:    bits = 10'b0000011100;
      4'd4:    bits = 10'b1000111110;
      4'd5:    bits = 10'b1001111010;
      4'd6:    bits = 10'b1111111100;
      4'd7:    bits = 10'b0111111000;
      4'd8:    bits = 10'b0011111000;
      4'd9:    bits = 10'b0001110000;
      default: bits = 10'b0000000000;
    endcase
    return bits;
  endfunction

  function automatic logic [9:0] leg_row(input logic [1:0] frame, input logic second);
    logic [9:0] bits;
    case ({frame, second})
      3'b000:  bits = 10'b0001010000;
      3'b001:  bits = 10'b0001101100;
      3'b010:  bits = 10'b0001011000;
      3'b011:  bits = 10'b0001100000;
      3'b100:  bits = 10'b0011010000;
      3'b101:  bits = 10'b0000011000;
      default: bits = 10'b0000000000;
    endcase
    return bits;
  endfunction

  logic [1:0] frame;
  logic [6:0] offset;
  logic [3:0] row;
  logic [3:0] col;
  logic [9:0] row_bits;
  logic       in_range;
  logic       ink;
  logic [2:0] q_d;
  logic [2:0] q_q;

  always_comb begin
    in_range = (rom.address < 9'd360);
    if (rom.address >= 9'd240) begin
      frame  = 2'd2;
      offset = 7'(rom.address - 9'd240);
    end else if (rom.address >= 9'd120) begin
      frame  = 2'd1;
      offset = 7'(rom.address - 9'd120);
    end else begin
      frame  = 2'd0;
      offset = 7'(rom.address);
    end
    row = 4'(offset / 7'd10);
    col = 4'(offset % 7'd10);
    // Only rows 10 and 11 depend on the frame; row[0] picks between them.
    row_bits = (row < 4'd10) ? body_row(row) : leg_row(frame, row[0]);
    ink      = in_range && row_bits[4'd9 - col];
    q_d      = ink ? INK : PAPER;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      q_q <= PAPER;
    end else begin
      q_q <= q_d;
    end
  end

  assign rom.q = q_q;

endmodule

// File: tb/tb_dino_sprite_rom.sv
// Self-checking bench for dino_sprite_rom against a string-bitmap reference model.
module tb_dino_sprite_rom;
  localparam logic [2:0] INK   = 3'b000;
  localparam logic [2:0] PAPER = 3'b111;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  int   checks = 0;
  int   errors = 0;
  logic [2:0] obs [0:359];

  dino_sprite_rom_if bus ();

  dino_sprite_rom #(.INK(INK), .PAPER(PAPER)) dut (
    .clock  (clock),
    .resetn (resetn),
    .rom    (bus)
  );

  always #5 clock = ~clock;

  string body [10] = '{
    "......####", ".....##.##", ".....#####", ".....###..", "#...#####.",
    "#..####.#.", "########..", ".######...", "..#####...", "...###...."
  };
  string legs [3][2] = '{
    '{"...#.#....", "...##.##.."},
    '{"...#.##...", "...##....."},
    '{"..##.#....", ".....##..."}
  };

  function automatic logic [2:0] model(input int a);
    int    f, r, c;
    string s;
    if (a >= 360) return PAPER;
    f = a / 120;
    r = (a % 120) / 10;
    c = a % 10;
    s = (r < 10) ? body[r] : legs[f][r - 10];
    return (s.getc(c) == "#") ? INK : PAPER;
  endfunction

  task automatic check(input string tag, input logic [2:0] got, input logic [2:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: q=%b expected %b", tag, got, exp);
    end
  endtask

  // One clock: present address/reset, take the edge, then check q 1 time unit later.
  task automatic cyc(input int a, input logic rn, input logic [2:0] exp, input string tag);
    bus.address = 9'(a);
    resetn      = rn;
    @(posedge clock);
    #1;
    check(tag, bus.q, exp);
  endtask

  initial begin
    int inks;
    int ra;
    logic rrn;
    bus.address = 9'd6;
    resetn      = 1'b0;
    #2;

    cyc(6, 1'b0, PAPER, "reset_edge0");
    cyc(6, 1'b0, PAPER, "reset_edge1");
    cyc(6, 1'b1, INK,   "first_read");

    cyc(0,   1'b1, PAPER, "f0_addr0");
    cyc(6,   1'b1, INK,   "f0_addr6");
    cyc(17,  1'b1, PAPER, "f0_eye17");
    cyc(40,  1'b1, INK,   "f0_addr40");
    cyc(119, 1'b1, PAPER, "f0_addr119");

    cyc(116, 1'b1, INK,   "leg_f0_116");
    cyc(236, 1'b1, PAPER, "leg_f1_236");
    cyc(233, 1'b1, INK,   "leg_f1_233");
    cyc(345, 1'b1, INK,   "leg_f2_345");
    cyc(351, 1'b1, PAPER, "leg_f2_351");

    cyc(359, 1'b1, PAPER, "last_pixel_359");
    cyc(360, 1'b1, PAPER, "oor_360");
    cyc(400, 1'b1, PAPER, "oor_400");
    cyc(511, 1'b1, PAPER, "oor_511");

    // Continuous sweep with one reset cycle spliced in at address 200.
    for (int a = 0; a < 360; a++) begin
      if (a == 200) cyc(a, 1'b0, PAPER, "sweep_reset");
      cyc(a, 1'b1, model(a), $sformatf("sweep_%0d", a));
      obs[a] = bus.q;
    end

    for (int a = 0; a < 120; a++) begin
      if ((a / 10) < 10) begin
        check($sformatf("shared_f1_%0d", a), obs[a + 120], obs[a]);
        check($sformatf("shared_f2_%0d", a), obs[a + 240], obs[a]);
      end
    end

    inks = 0;
    for (int a = 0; a < 120; a++) if (obs[a] === INK) inks++;
    checks++;
    assert (inks == 56) else begin
      errors++;
      $error("FAIL f0_ink_count: count=%0d expected 56", inks);
    end

    // Random addresses across the full 9-bit space with occasional resets.
    for (int i = 0; i < 400; i++) begin
      ra  = int'($urandom_range(511, 0));
      rrn = ($urandom_range(15, 0) != 0);
      cyc(ra, rrn, rrn ? model(ra) : PAPER, $sformatf("rand_%0d_addr%0d", i, ra));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
